// File: rtl/game_move_sequencer.sv
// 4x4 sliding-tile board engine: edge-detected gamepad input, one-line-per-cycle
// moves with merge scoring, LFSR-driven tile spawning and end-of-game detection.
module game_move_sequencer #(
   parameter int WIN_EXP = 11
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        up,
   input  logic        down,
   input  logic        left,
   input  logic        right,
   input  logic        start,
   input  logic        ld_en,
   input  logic [3:0]  ld_addr,
   input  logic [3:0]  ld_data,
   input  logic [3:0]  rd_addr,
   output logic [3:0]  rd_tile,
   output logic        busy,
   output logic        game_over,
   output logic        won,
   output logic [15:0] score
);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_MOVE, S_SPAWN, S_CHECK} state_t;
   typedef enum logic [1:0] {D_LEFT, D_RIGHT, D_UP, D_DOWN} dir_t;

   localparam logic [3:0] WIN_TILE = 4'(WIN_EXP);

   state_t      state, state_nxt;
   dir_t        move_dir, dir_sel;
   logic [3:0]  board [16];
   logic [15:0] lfsr;
   logic [4:0]  btn_prev, btn_now, btn_ev;
   logic [1:0]  line_idx, spawns_left;
   logic        moved;
   logic [3:0]  spawn_pos, spawn_cnt;
   logic        start_ev, accept_move, spawn_hit, spawn_done;

   logic [3:0]  line_addr [4];
   logic [3:0]  line_in [4];
   logic [3:0]  line_out [4];
   logic [3:0]  comp [5];
   logic [2:0]  comp_cnt, out_cnt;
   logic        skip_next, line_changed, line_won;
   logic [16:0] line_gain, score_sum;
   logic [15:0] score_nxt;
   logic        board_dead;

   // Element k of line idx, ordered so that k = 0 is the cell against the wall.
   function automatic logic [3:0] cell_addr(input dir_t d, input logic [1:0] idx,
                                            input logic [1:0] k);
      case (d)
         D_LEFT:  cell_addr = {idx, k};
         D_RIGHT: cell_addr = {idx, ~k};
         D_UP:    cell_addr = {k, idx};
         default: cell_addr = {~k, idx};
      endcase
   endfunction

   assign btn_now     = {start, down, up, right, left};
   assign btn_ev      = btn_now & ~btn_prev;
   assign start_ev    = btn_ev[4];
   assign accept_move = !start_ev && $onehot(btn_ev[3:0]) && !game_over;
   assign rd_tile     = board[rd_addr];
   assign spawn_hit   = (board[spawn_pos] == 4'd0);
   assign spawn_done  = spawn_hit || (spawn_cnt == 4'd15);

   always_comb begin
      dir_sel = D_DOWN;
      if (btn_ev[0])      dir_sel = D_LEFT;
      else if (btn_ev[1]) dir_sel = D_RIGHT;
      else if (btn_ev[2]) dir_sel = D_UP;
   end

   // Slide one line: compact nonzero tiles toward the wall, then merge pairs
   // wall-first; a merged tile is skipped so it cannot merge again this move.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         line_addr[k] = cell_addr(move_dir, line_idx, 2'(k));
         line_in[k]   = board[line_addr[k]];
      end
      for (int k = 0; k < 5; k++) comp[k] = 4'd0;
      comp_cnt = 3'd0;
      for (int k = 0; k < 4; k++) begin
         if (line_in[k] != 4'd0) begin
            comp[comp_cnt] = line_in[k];
            comp_cnt = comp_cnt + 3'd1;
         end
      end
      for (int k = 0; k < 4; k++) line_out[k] = 4'd0;
      out_cnt   = 3'd0;
      skip_next = 1'b0;
      line_gain = 17'd0;
      line_won  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (skip_next) begin
            skip_next = 1'b0;
         end else if (comp[3'(k)] != 4'd0 && comp[3'(k)] == comp[3'(k + 1)] &&
                      comp[3'(k)] != 4'hF) begin
            line_out[out_cnt[1:0]] = comp[3'(k)] + 4'd1;
            line_gain = line_gain + (17'd1 << (comp[3'(k)] + 4'd1));
            if (comp[3'(k)] + 4'd1 == WIN_TILE) line_won = 1'b1;
            skip_next = 1'b1;
            out_cnt = out_cnt + 3'd1;
         end else begin
            line_out[out_cnt[1:0]] = comp[3'(k)];
            out_cnt = out_cnt + 3'd1;
         end
      end
      line_changed = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (line_out[k] != line_in[k]) line_changed = 1'b1;
      end
      score_sum = {1'b0, score} + line_gain;
      score_nxt = score_sum[16] ? 16'hFFFF : score_sum[15:0];
   end

   // The board is stuck when it is full and no two orthogonal neighbours match.
   always_comb begin
      board_dead = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (board[4'(i)] == 4'd0) board_dead = 1'b0;
      end
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 3; c++) begin
            if (board[4'(r * 4 + c)] == board[4'(r * 4 + c + 1)]) board_dead = 1'b0;
         end
      end
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (board[4'(r * 4 + c)] == board[4'(r * 4 + c + 4)]) board_dead = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (start_ev)         state_nxt = S_CLEAR;
            else if (accept_move) state_nxt = S_MOVE;
         end
         S_CLEAR: state_nxt = S_SPAWN;
         S_MOVE: begin
            if (line_idx == 2'd3) state_nxt = (moved || line_changed) ? S_SPAWN : S_CHECK;
         end
         S_SPAWN: begin
            if (spawn_done && spawns_left != 2'd2) state_nxt = S_CHECK;
         end
         S_CHECK: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Board, score, flags and spawn bookkeeping. The spawn start cell is taken
   // from the LFSR on the edge that enters SPAWN, and again for a second spawn.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) board[i] <= 4'd0;
         lfsr        <= 16'hACE1;
         btn_prev    <= 5'd0;
         score       <= 16'd0;
         won         <= 1'b0;
         game_over   <= 1'b0;
         move_dir    <= D_LEFT;
         line_idx    <= 2'd0;
         moved       <= 1'b0;
         spawns_left <= 2'd0;
         spawn_pos   <= 4'd0;
         spawn_cnt   <= 4'd0;
      end else begin
         lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         btn_prev <= btn_now;
         case (state)
            S_IDLE: begin
               if (ld_en) board[ld_addr] <= ld_data;
               if (accept_move) begin
                  move_dir <= dir_sel;
                  line_idx <= 2'd0;
                  moved    <= 1'b0;
               end
            end
            S_CLEAR: begin
               for (int i = 0; i < 16; i++) board[i] <= 4'd0;
               score       <= 16'd0;
               won         <= 1'b0;
               game_over   <= 1'b0;
               spawns_left <= 2'd2;
               spawn_pos   <= lfsr[3:0];
               spawn_cnt   <= 4'd0;
            end
            S_MOVE: begin
               for (int k = 0; k < 4; k++) board[line_addr[k]] <= line_out[k];
               score <= score_nxt;
               if (line_won) won <= 1'b1;
               moved       <= moved | line_changed;
               line_idx    <= line_idx + 2'd1;
               spawns_left <= 2'd1;
               spawn_pos   <= lfsr[3:0];
               spawn_cnt   <= 4'd0;
            end
            S_SPAWN: begin
               if (spawn_hit) board[spawn_pos] <= (lfsr[7:4] == 4'd0) ? 4'd2 : 4'd1;
               if (spawn_done) begin
                  spawns_left <= spawns_left - 2'd1;
                  spawn_pos   <= lfsr[3:0];
                  spawn_cnt   <= 4'd0;
               end else begin
                  spawn_pos <= spawn_pos + 4'd1;
                  spawn_cnt <= spawn_cnt + 4'd1;
               end
            end
            S_CHECK: game_over <= board_dead;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_game_move_sequencer.sv
// Self-checking bench for game_move_sequencer: directed scenarios plus random
// boards checked against a queue-based slide/merge reference model.
module tb_game_move_sequencer;

   localparam int WIN = 11;

   logic        clk, rst_n, up, down, left, right, start, ld_en;
   logic [3:0]  ld_addr, ld_data, rd_addr, rd_tile;
   logic        busy, game_over, won;
   logic [15:0] score;

   int vectors, miscompares;
   int pre_b[16], exp_b[16], obs_b[16];
   int m_score, m_gain;
   bit m_won, m_hit, m_changed;

   game_move_sequencer #(.WIN_EXP(WIN)) dut (
      .clk(clk), .rst_n(rst_n), .up(up), .down(down), .left(left), .right(right),
      .start(start), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .rd_addr(rd_addr), .rd_tile(rd_tile), .busy(busy), .game_over(game_over),
      .won(won), .score(score)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference move: gather each line wall-first, merge with a queue, pad zeros.
   function automatic void model_move(input int d);
      int idx[4];
      int q[$];
      int res[$];
      int a;
      m_gain = 0;
      m_hit  = 0;
      for (int i = 0; i < 16; i++) exp_b[i] = pre_b[i];
      for (int ln = 0; ln < 4; ln++) begin
         q.delete();
         res.delete();
         for (int k = 0; k < 4; k++) begin
            case (d)
               0:       idx[k] = ln * 4 + k;
               1:       idx[k] = ln * 4 + (3 - k);
               2:       idx[k] = k * 4 + ln;
               default: idx[k] = (3 - k) * 4 + ln;
            endcase
            if (pre_b[idx[k]] != 0) q.push_back(pre_b[idx[k]]);
         end
         while (q.size() > 0) begin
            a = q.pop_front();
            if (q.size() > 0 && q[0] == a && a != 15) begin
               void'(q.pop_front());
               res.push_back(a + 1);
               m_gain += 1 << (a + 1);
               if (a + 1 == WIN) m_hit = 1;
            end else begin
               res.push_back(a);
            end
         end
         while (res.size() < 4) res.push_back(0);
         for (int k = 0; k < 4; k++) exp_b[idx[k]] = res[k];
      end
      m_changed = 0;
      for (int i = 0; i < 16; i++) if (exp_b[i] != pre_b[i]) m_changed = 1;
   endfunction

   function automatic void model_commit();
      m_score = (m_score + m_gain > 65535) ? 65535 : m_score + m_gain;
      if (m_hit) m_won = 1;
   endfunction

   // 1 when the observed board equals the expected one, apart from exactly one
   // new 1/2 tile in a formerly empty cell if a spawn is expected.
   function automatic int spawn_ok(input bit expect_spawn);
      int diffs;
      bit bad;
      diffs = 0;
      bad   = 0;
      for (int i = 0; i < 16; i++) begin
         if (obs_b[i] != exp_b[i]) begin
            diffs++;
            if (exp_b[i] != 0 || obs_b[i] < 1 || obs_b[i] > 2) bad = 1;
         end
      end
      return (!bad && diffs == (expect_spawn ? 1 : 0)) ? 1 : 0;
   endfunction

   function automatic int count_nonzero();
      int n;
      n = 0;
      for (int i = 0; i < 16; i++) if (obs_b[i] != 0) n++;
      return n;
   endfunction

   function automatic bit obs_dead();
      for (int i = 0; i < 16; i++) begin
         if (obs_b[i] == 0) return 0;
         if (i % 4 != 3 && obs_b[i] == obs_b[i + 1]) return 0;
         if (i < 12 && obs_b[i] == obs_b[i + 4]) return 0;
      end
      return 1;
   endfunction

   task automatic read_board();
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i);
         #1;
         obs_b[i] = int'(rd_tile);
      end
   endtask

   task automatic load_board();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         ld_en   = 1'b1;
         ld_addr = 4'(i);
         ld_data = 4'(pre_b[i]);
      end
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   task automatic clear_board();
      for (int i = 0; i < 16; i++) pre_b[i] = 0;
   endtask

   task automatic press(input int d);
      @(negedge clk);
      case (d)
         0:       left  = 1'b1;
         1:       right = 1'b1;
         2:       up    = 1'b1;
         default: down  = 1'b1;
      endcase
      @(negedge clk);
      {left, right, up, down} = 4'b0;
   endtask

   task automatic wait_idle(input int limit, output int cycles);
      cycles = 0;
      while (busy === 1'b1 && cycles < limit) begin
         cycles++;
         @(negedge clk);
      end
   endtask

   task automatic new_game();
      int cyc;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle(60, cyc);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL new_game_timeout: busy=%b after %0d cycles, required 0", busy, cyc);
      end
      m_score = 0;
      m_won   = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      {up, down, left, right, start, ld_en} = 6'b0;
      ld_addr = 4'd0;
      ld_data = 4'd0;
      rd_addr = 4'd0;
      repeat (3) @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || game_over !== 1'b0 || won !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_flags: busy=%b game_over=%b won=%b, required 000", busy, game_over, won);
      end
      vectors++;
      if (score !== 16'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_score: got %0d, required 0", score);
      end
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      read_board();
      vectors++;
      if (count_nonzero() != 0) begin
         miscompares++;
         $display("[TB] FAIL reset_board_empty: %0d nonzero cells, required 0", count_nonzero());
      end
      m_score = 0;
      m_won   = 0;
   endtask

   task automatic test_start();
      int cyc, bad;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle(40, cyc);
      vectors++;
      if (busy !== 1'b0 || cyc > 35) begin
         miscompares++;
         $display("[TB] FAIL start_latency: busy=%b after %0d cycles, required idle within 35", busy, cyc);
      end
      read_board();
      bad = 0;
      for (int i = 0; i < 16; i++) if (obs_b[i] > 2) bad++;
      vectors++;
      if (count_nonzero() != 2 || bad != 0) begin
         miscompares++;
         $display("[TB] FAIL start_tiles: %0d tiles (%0d not exp 1/2), required 2 of exp 1/2", count_nonzero(), bad);
      end
      vectors++;
      if (score !== 16'd0 || game_over !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL start_state: score=%0d game_over=%b, required 0 0", score, game_over);
      end
   endtask

   task automatic test_merge_pairs();
      int cyc;
      new_game();
      clear_board();
      pre_b[0] = 1; pre_b[1] = 1; pre_b[2] = 2; pre_b[3] = 2;
      load_board();
      model_move(0);
      press(0);
      wait_idle(40, cyc);
      model_commit();
      read_board();
      vectors++;
      if (obs_b[0] != 2 || obs_b[1] != 3) begin
         miscompares++;
         $display("[TB] FAIL pairs_row0: got %0d,%0d, required 2,3", obs_b[0], obs_b[1]);
      end
      vectors++;
      if (spawn_ok(1) != 1) begin
         miscompares++;
         $display("[TB] FAIL pairs_spawn: board deviates beyond one new tile, %0d nonzero cells, required 3", count_nonzero());
      end
      vectors++;
      if (score !== 16'd12) begin
         miscompares++;
         $display("[TB] FAIL pairs_score: got %0d, required 12", score);
      end
      vectors++;
      if (cyc < 6 || cyc > 21) begin
         miscompares++;
         $display("[TB] FAIL pairs_latency: got %0d busy cycles, required 6..21", cyc);
      end
   endtask

   task automatic test_four_merge();
      int cyc;
      new_game();
      clear_board();
      for (int i = 0; i < 4; i++) pre_b[i] = 1;
      load_board();
      model_move(1);
      press(1);
      wait_idle(40, cyc);
      model_commit();
      read_board();
      vectors++;
      if (obs_b[2] != 2 || obs_b[3] != 2 || spawn_ok(1) != 1) begin
         miscompares++;
         $display("[TB] FAIL four_row0: got %0d,%0d,%0d,%0d, required 0,0,2,2 plus one spawn", obs_b[0], obs_b[1], obs_b[2], obs_b[3]);
      end
      vectors++;
      if (score !== 16'd8) begin
         miscompares++;
         $display("[TB] FAIL four_score: got %0d, required 8", score);
      end
   endtask

   task automatic test_game_over();
      int cyc;
      new_game();
      for (int i = 0; i < 16; i++) pre_b[i] = ((i / 4 + i % 4) % 2 == 1) ? 2 : 1;
      load_board();
      model_move(0);
      press(0);
      wait_idle(40, cyc);
      read_board();
      vectors++;
      if (cyc != 5) begin
         miscompares++;
         $display("[TB] FAIL stuck_latency: got %0d busy cycles, required 5", cyc);
      end
      vectors++;
      if (spawn_ok(0) != 1) begin
         miscompares++;
         $display("[TB] FAIL stuck_board: board changed, %0d nonzero cells, required 16 unchanged", count_nonzero());
      end
      vectors++;
      if (game_over !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL stuck_game_over: got %b, required 1", game_over);
      end
      press(2);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL over_ignores_move: busy=%b, required 0", busy);
      end
      new_game();
      vectors++;
      if (game_over !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL start_clears_over: got %b, required 0", game_over);
      end
   endtask

   task automatic test_saturate();
      int cyc;
      new_game();
      clear_board();
      pre_b[0] = 15; pre_b[1] = 15;
      load_board();
      model_move(0);
      press(0);
      wait_idle(40, cyc);
      read_board();
      vectors++;
      if (cyc != 5 || spawn_ok(0) != 1 || score !== 16'd0) begin
         miscompares++;
         $display("[TB] FAIL exp15_no_merge: cycles=%0d cell0=%0d score=%0d, required 5 15 0", cyc, obs_b[0], score);
      end
      new_game();
      clear_board();
      for (int i = 0; i < 4; i++) pre_b[i] = 14;
      load_board();
      model_move(0);
      press(0);
      wait_idle(40, cyc);
      model_commit();
      read_board();
      vectors++;
      if (obs_b[0] != 15 || obs_b[1] != 15 || spawn_ok(1) != 1) begin
         miscompares++;
         $display("[TB] FAIL sat_row0: got %0d,%0d, required 15,15 plus one spawn", obs_b[0], obs_b[1]);
      end
      vectors++;
      if (score !== 16'hFFFF) begin
         miscompares++;
         $display("[TB] FAIL sat_score: got %0d, required 65535", score);
      end
   endtask

   task automatic test_simultaneous();
      int cyc, seen, rises;
      bit prev_busy;
      new_game();
      clear_board();
      pre_b[1] = 1;
      pre_b[6] = 3;
      load_board();
      @(negedge clk);
      left = 1'b1;
      up   = 1'b1;
      @(negedge clk);
      left = 1'b0;
      up   = 1'b0;
      seen = 0;
      repeat (10) begin
         if (busy !== 1'b0) seen++;
         @(negedge clk);
      end
      vectors++;
      if (seen != 0) begin
         miscompares++;
         $display("[TB] FAIL dual_edge_ignored: busy seen %0d cycles, required 0", seen);
      end
      model_move(0);
      @(negedge clk);
      left      = 1'b1;
      rises     = 0;
      prev_busy = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (busy === 1'b1 && !prev_busy) rises++;
         prev_busy = (busy === 1'b1);
      end
      left = 1'b0;
      wait_idle(40, cyc);
      model_commit();
      read_board();
      vectors++;
      if (rises != 1) begin
         miscompares++;
         $display("[TB] FAIL held_one_move: got %0d moves, required 1", rises);
      end
      vectors++;
      if (spawn_ok(1) != 1) begin
         miscompares++;
         $display("[TB] FAIL held_board: cell1=%0d cell4=%0d, required 0 and 3 plus one spawn", obs_b[1], obs_b[4]);
      end
      @(negedge clk);
      start = 1'b1;
      left  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      left  = 1'b0;
      wait_idle(40, cyc);
      m_score = 0;
      m_won   = 0;
      read_board();
      vectors++;
      if (count_nonzero() != 2 || score !== 16'd0) begin
         miscompares++;
         $display("[TB] FAIL start_beats_dir: %0d tiles score=%0d, required 2 tiles score 0", count_nonzero(), score);
      end
   endtask

   task automatic test_win();
      int cyc;
      new_game();
      clear_board();
      pre_b[0] = 10; pre_b[1] = 10;
      load_board();
      model_move(0);
      press(0);
      wait_idle(40, cyc);
      model_commit();
      read_board();
      vectors++;
      if (obs_b[0] != 11 || won !== 1'b1 || score !== 16'd2048) begin
         miscompares++;
         $display("[TB] FAIL win_merge: cell0=%0d won=%b score=%0d, required 11 1 2048", obs_b[0], won, score);
      end
      press(1);
      wait_idle(40, cyc);
      vectors++;
      if (cyc < 6 || won !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL win_play_on: cycles=%0d won=%b, required >=6 and 1", cyc, won);
      end
      new_game();
      vectors++;
      if (won !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL start_clears_won: got %b, required 0", won);
      end
   endtask

   task automatic test_abort();
      new_game();
      clear_board();
      pre_b[0] = 1; pre_b[1] = 1; pre_b[2] = 2; pre_b[3] = 2;
      load_board();
      press(0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      read_board();
      vectors++;
      if (busy !== 1'b0 || count_nonzero() != 0 || score !== 16'd0) begin
         miscompares++;
         $display("[TB] FAIL abort_move: busy=%b tiles=%0d score=%0d, required 0 0 0", busy, count_nonzero(), score);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      read_board();
      vectors++;
      if (busy !== 1'b0 || count_nonzero() != 0) begin
         miscompares++;
         $display("[TB] FAIL abort_spawn: busy=%b tiles=%0d, required 0 0", busy, count_nonzero());
      end
      @(negedge clk);
      rst_n   = 1'b1;
      m_score = 0;
      m_won   = 0;
   endtask

   task automatic test_random();
      int cyc, d, r;
      new_game();
      for (int it = 0; it < 40; it++) begin
         if (game_over === 1'b1) new_game();
         for (int i = 0; i < 16; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 3)      pre_b[i] = 0;
            else if (r < 9) pre_b[i] = int'($urandom_range(1, 4));
            else            pre_b[i] = int'($urandom_range(9, 15));
         end
         d = int'($urandom_range(0, 3));
         load_board();
         model_move(d);
         press(d);
         wait_idle(40, cyc);
         model_commit();
         read_board();
         vectors++;
         if (spawn_ok(m_changed) != 1) begin
            miscompares++;
            $display("[TB] FAIL rand_board it=%0d dir=%0d: board deviates from model (changed=%0b)", it, d, m_changed);
         end
         vectors++;
         if (score !== 16'(m_score) || won !== m_won) begin
            miscompares++;
            $display("[TB] FAIL rand_score it=%0d: score=%0d won=%b, required %0d %b", it, score, won, m_score, m_won);
         end
         vectors++;
         if (m_changed ? (cyc < 6 || cyc > 21) : (cyc != 5)) begin
            miscompares++;
            $display("[TB] FAIL rand_latency it=%0d: got %0d cycles, changed=%0b", it, cyc, m_changed);
         end
         vectors++;
         if (game_over !== obs_dead()) begin
            miscompares++;
            $display("[TB] FAIL rand_game_over it=%0d: got %b, required %b", it, game_over, obs_dead());
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_start();
      test_merge_pairs();
      test_four_merge();
      test_game_over();
      test_saturate();
      test_simultaneous();
      test_win();
      test_abort();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/game_move_sequencer.md
GAME_MOVE_SEQUENCER -- requirements
Module: game_move_sequencer

Interface
REQ-001 SHALL have parameter WIN_EXP, default 11, tile exponent that sets won (2^11 = 2048).
REQ-002 SHALL have port clk  in  1  system clock, single clock domain.
REQ-003 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports up, down, left, right  in  1 each  decoded gamepad levels, 1 = pressed.
REQ-005 SHALL have port start  in  1  new-game button level.
REQ-006 SHALL have ports ld_en (1), ld_addr (4), ld_data (4)  in  board preload write.
REQ-007 SHALL have port rd_addr  in  4  renderer read address, addr = row*4+col, row 0 at top.
REQ-008 SHALL have port rd_tile  out  4  exponent at rd_addr, combinational read, 0 = empty.
REQ-009 SHALL have ports busy, game_over, won  out  1 each.
REQ-010 SHALL have port score  out  16  running score.

Function
REQ-011 SHALL hold a 4x4 board of 4-bit exponents; tile value = 2^exp; exp 0 = empty.
REQ-012 SHALL rising-edge detect each button against its previous-cycle level; a held button yields one event only.
REQ-013 In IDLE, a direction event SHALL be accepted only if exactly one direction edge occurs that cycle and game_over=0; otherwise it is ignored.
REQ-014 Events in non-IDLE states SHALL be dropped, not queued.
REQ-015 start edge SHALL win over a simultaneous direction edge and SHALL be accepted in IDLE even when game_over=1.
REQ-016 ld_en SHALL write ld_data to ld_addr only in IDLE; it SHALL be ignored otherwise.
REQ-017 States: IDLE, CLEAR, MOVE, SPAWN, CHECK; busy=1 in every state except IDLE.
REQ-018 CLEAR (1 cycle) SHALL zero the board, score, won and game_over, then perform SPAWN twice, then CHECK.
REQ-019 MOVE SHALL process one line per cycle, line index 0..3, 4 cycles total.
REQ-020 Line order toward the wall: left = row r, cols 0..3; right = row r, cols 3..0; up = col c, rows 0..3; down = col c, rows 3..0.
REQ-021 Per line, the block SHALL compact nonzero tiles toward the wall and then merge equal adjacent pairs starting nearest the wall.
REQ-022 Each tile SHALL merge at most once per move; the merged exponent SHALL be exp+1.
REQ-023 Exponent 15 SHALL never merge.
REQ-024 Each merge SHALL add 2^(exp+1) to score; score SHALL saturate at 0xFFFF.
REQ-025 won SHALL set, sticky, when any merge produces exp == WIN_EXP; play SHALL continue afterwards.
REQ-026 A moved flag SHALL record whether any cell changed; if the flag is 0, the block SHALL skip SPAWN and go directly to CHECK.
REQ-027 LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 0xACE1, advancing every cycle.
REQ-028 SPAWN SHALL latch start = lfsr[3:0] on entry and then test one cell per cycle, incrementing mod 16.
REQ-029 At the first empty cell, SPAWN SHALL write exp 2 if lfsr[7:4]==0, else exp 1, then exit; worst case is 16 cycles.
REQ-030 If all 16 cells are full, SPAWN SHALL exit without a write after 16 cycles.
REQ-031 CHECK (1 cycle) SHALL set game_over=1 iff no cell is empty and no horizontally or vertically adjacent pair is equal; it SHALL then return to IDLE.
REQ-032 Latency SHALL be: move with change = 4 + (1..16) + 1 cycles; move without change = 5 cycles.

Reset
REQ-033 On rst_n low, asynchronously: board all 0, score 0, won 0, game_over 0, busy 0, state IDLE, LFSR 0xACE1, edge-detect history 0.
REQ-034 Reset asserted mid-MOVE or mid-SPAWN SHALL abort the operation with no partial write surviving.
REQ-035 After reset the board SHALL stay empty until a start event.

Verification
REQ-036 Reset, then pulse start -> busy drops within 35 cycles; exactly 2 nonzero cells, each exp 1 or 2; score 0.
REQ-037 Preload row 0 = [1,1,2,2], rest empty, then left -> row 0 = [2,3,0,0], score 12, exactly one extra tile elsewhere.
REQ-038 Preload row 0 = [1,1,1,1], then right -> row 0 = [0,0,2,2], score 8.
REQ-039 Preload checkerboard of exp 1/2 with no empties, then left -> no cell change, no spawn, busy for 5 cycles, game_over=1; a following up edge is ignored.
REQ-040 left and up edges in the same cycle -> ignored, busy stays 0. left held 100 cycles -> exactly one move.
REQ-041 Preload [10,10,0,0], then left -> cell 0 = 11, won=1, score 2048; then start -> won=0.
